// File: rtl/t_ff_pkg.sv
// Shared definitions for the toggle/count primitive.
//   mode_t          : operation select encoding on the 'mode' input
//   DEF_WIDTH       : default register width
//   DEF_RESET_VAL   : default post-reset register value
package t_ff_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'b00,
    MODE_TOGGLE = 2'b01,
    MODE_UP     = 2'b10,
    MODE_DOWN   = 2'b11
  } mode_t;

  localparam int DEF_WIDTH     = 4;
  localparam int DEF_RESET_VAL = 0;

endpackage

// File: rtl/t_ff_cell.sv
// One-bit T flip-flop with synchronous reset to a per-bit reset value.
//   CLK     : clock, state updates on posedge
//   res     : synchronous active-high reset, loads rst_val
//   rst_val : value taken by q on reset
//   t       : toggle request, q inverts on the edge when high
//   q       : registered bit value
module t_ff_cell (
  input  logic CLK,
  input  logic res,
  input  logic rst_val,
  input  logic t,
  output logic q
);

  always_ff @(posedge CLK) begin
    if (res) q <= rst_val;
    else     q <= q ^ t;
  end

endmodule

// File: rtl/t_ff_counter.sv
// WIDTH-bit register built from T cells, supporting hold, per-bit toggle,
// modulo-MODULUS up/down counting and synchronous parallel load.
//   CLK     : clock, all state updates on posedge
//   res     : synchronous active-high reset (highest priority)
//   en      : enables the mode operation; load ignores it
//   mode    : 00 hold, 01 toggle, 10 count up, 11 count down
//   T       : per-bit toggle mask for toggle mode
//   load    : synchronous parallel load of D (no modulus clamp)
//   D       : load data
//   clr_ovf : clears the sticky overflow flag (a same-cycle wrap wins)
//   Q       : register value
//   wrap    : one-cycle registered pulse following a wrap/snap event
//   ovf     : sticky flag set by any wrap/snap event
module t_ff_counter
  import t_ff_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter int               MODULUS   = 2**WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEF_RESET_VAL)
) (
  input  logic             CLK,
  input  logic             res,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] T,
  input  logic             load,
  input  logic [WIDTH-1:0] D,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] Q,
  output logic             wrap,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  mode_t            mode_sel;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] t_mask;
  logic             wrap_evt;

  assign mode_sel = mode_t'(mode);

  // Next register value; reset is handled inside the cells themselves.
  always_comb begin
    q_next   = Q;
    wrap_evt = 1'b0;
    if (load) begin
      q_next = D;
    end else if (en) begin
      case (mode_sel)
        MODE_TOGGLE: q_next = Q ^ T;
        MODE_UP: begin
          if (Q < MAX_VAL) begin
            q_next = Q + WIDTH'(1);
          end else begin
            q_next   = '0;
            wrap_evt = 1'b1;
          end
        end
        MODE_DOWN: begin
          // Zero wraps to the top; out-of-range values snap to the top.
          if (Q == '0 || Q > MAX_VAL) begin
            q_next   = MAX_VAL;
            wrap_evt = 1'b1;
          end else begin
            q_next = Q - WIDTH'(1);
          end
        end
        default: q_next = Q;
      endcase
    end
  end

  // Every update, including load, is expressed as a toggle mask.
  assign t_mask = Q ^ q_next;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    t_ff_cell u_cell (
      .CLK     (CLK),
      .res     (res),
      .rst_val (RESET_VAL[i]),
      .t       (t_mask[i]),
      .q       (Q[i])
    );
  end

  always_ff @(posedge CLK) begin
    if (res) begin
      wrap <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      wrap <= wrap_evt;
      if (wrap_evt)     ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_t_ff_counter.sv
module tb_t_ff_counter;

  localparam int W   = 4;
  localparam int MOD = 10;

  logic         CLK = 1'b0;
  logic         res = 1'b1;
  logic         en = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] T = '0;
  logic         load = 1'b0;
  logic [W-1:0] D = '0;
  logic         clr_ovf = 1'b0;
  logic [W-1:0] Q;
  logic         wrap;
  logic         ovf;

  int n_chk  = 0;
  int n_pass = 0;

  // reference model state
  int mq = 0;
  bit mw = 1'b0;
  bit mo = 1'b0;

  always #5 CLK = ~CLK;

  t_ff_counter #(.WIDTH(W), .MODULUS(MOD), .RESET_VAL(4'd0)) dut (
    .CLK     (CLK),
    .res     (res),
    .en      (en),
    .mode    (mode),
    .T       (T),
    .load    (load),
    .D       (D),
    .clr_ovf (clr_ovf),
    .Q       (Q),
    .wrap    (wrap),
    .ovf     (ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // Behavioural model of one clock edge, straight from the operation rules.
  task automatic model_edge(input bit r, input bit l, input int d, input bit e,
                            input int m, input int t, input bit c);
    bit evt = 1'b0;
    if (r) begin
      mq = 0; mw = 1'b0; mo = 1'b0;
      return;
    end
    if (l) mq = d;
    else if (e) begin
      if (m == 1) mq = mq ^ t;
      else if (m == 2) begin
        if (mq >= MOD - 1) begin mq = 0; evt = 1'b1; end
        else mq = mq + 1;
      end else if (m == 3) begin
        if (mq == 0 || mq > MOD - 1) begin mq = MOD - 1; evt = 1'b1; end
        else mq = mq - 1;
      end
    end
    mw = evt;
    if (evt) mo = 1'b1;
    else if (c) mo = 1'b0;
  endtask

  // Drive on negedge, advance the model, sample 1 time unit after posedge.
  task automatic step(input bit r, input bit l, input logic [W-1:0] d, input bit e,
                      input logic [1:0] m, input logic [W-1:0] t, input bit c);
    @(negedge CLK);
    res = r; load = l; D = d; en = e; mode = m; T = t; clr_ovf = c;
    model_edge(r, l, int'(d), e, int'(m), int'(t), c);
    @(posedge CLK);
    #1;
    chk("q",    32'(Q),    32'(mq));
    chk("wrap", 32'(wrap), 32'(mw));
    chk("ovf",  32'(ovf),  32'(mo));
  endtask

  int wraps;

  initial begin
    // reset
    step(1, 0, 4'd0, 0, 2'd0, 4'd0, 0);
    chk("rst_q", 32'(Q), 32'd0);

    // toggle with T=0101 from 0
    step(0, 0, 4'd0, 1, 2'd1, 4'b0101, 0); chk("tog_a", 32'(Q), 32'd5);
    step(0, 0, 4'd0, 1, 2'd1, 4'b0101, 0); chk("tog_b", 32'(Q), 32'd0);
    step(0, 0, 4'd0, 1, 2'd1, 4'b0101, 0); chk("tog_c", 32'(Q), 32'd5);
    chk("tog_wrap", 32'(wrap), 32'd0);
    // toggle into out-of-range value, no clamp
    step(0, 0, 4'd0, 1, 2'd1, 4'b1000, 0); chk("tog_noclamp", 32'(Q), 32'd13);

    // up wrap from 8
    step(0, 1, 4'd8, 0, 2'd0, 4'd0, 0);
    step(0, 0, 4'd0, 1, 2'd2, 4'd0, 0); chk("up_9", 32'(Q), 32'd9);
    step(0, 0, 4'd0, 1, 2'd2, 4'd0, 0);
    chk("up_wrap_q", 32'(Q), 32'd0); chk("up_wrap_w", 32'(wrap), 32'd1);
    chk("up_wrap_o", 32'(ovf), 32'd1);
    step(0, 0, 4'd0, 1, 2'd2, 4'd0, 0);
    chk("up_after_q", 32'(Q), 32'd1); chk("up_after_w", 32'(wrap), 32'd0);
    chk("up_after_o", 32'(ovf), 32'd1);

    // reset with Q=7, ovf=1
    step(0, 1, 4'd7, 0, 2'd0, 4'd0, 0);
    chk("pre_rst_o", 32'(ovf), 32'd1);
    step(1, 0, 4'd0, 1, 2'd2, 4'd0, 0);
    chk("rst7_q", 32'(Q), 32'd0); chk("rst7_o", 32'(ovf), 32'd0);

    // down wrap from 0, then snap from 14
    step(0, 0, 4'd0, 1, 2'd3, 4'd0, 0);
    chk("dn_wrap_q", 32'(Q), 32'd9); chk("dn_wrap_w", 32'(wrap), 32'd1);
    step(0, 1, 4'hE, 1, 2'd3, 4'd0, 0);
    chk("load_e", 32'(Q), 32'd14); chk("load_w", 32'(wrap), 32'd0);
    step(0, 0, 4'd0, 1, 2'd3, 4'd0, 0);
    chk("snap_q", 32'(Q), 32'd9); chk("snap_w", 32'(wrap), 32'd1);
    step(0, 0, 4'd0, 1, 2'd3, 4'd0, 0); chk("dn_8", 32'(Q), 32'd8);

    // priority
    step(0, 1, 4'd3, 1, 2'd2, 4'd0, 0); chk("load_over_up", 32'(Q), 32'd3);
    step(1, 1, 4'd5, 1, 2'd2, 4'd0, 0); chk("res_over_load", 32'(Q), 32'd0);
    step(0, 1, 4'd9, 0, 2'd0, 4'd0, 0);
    step(0, 0, 4'd0, 1, 2'd2, 4'd0, 1);
    chk("clr_vs_wrap_o", 32'(ovf), 32'd1);
    step(0, 0, 4'd0, 0, 2'd2, 4'd0, 1);
    chk("clr_o", 32'(ovf), 32'd0);

    // mid-count reset
    step(1, 0, 4'd0, 0, 2'd0, 4'd0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 4'd0, 1, 2'd2, 4'd0, 0);
    chk("mid_6", 32'(Q), 32'd6);
    step(1, 0, 4'd0, 1, 2'd2, 4'd0, 0); chk("mid_rst", 32'(Q), 32'd0);
    step(0, 0, 4'd0, 1, 2'd2, 4'd0, 0); chk("mid_resume", 32'(Q), 32'd1);

    // wrap period: 30 continuous up edges starting at 0 give 3 pulses
    step(1, 0, 4'd0, 0, 2'd0, 4'd0, 0);
    wraps = 0;
    for (int i = 0; i < 30; i++) begin
      step(0, 0, 4'd0, 1, 2'd2, 4'd0, 0);
      if (wrap) wraps++;
    end
    chk("wrap_period", 32'(wraps), 32'd3);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      bit r, l, e, c;
      logic [1:0] m;
      logic [W-1:0] d, t;
      r = ($urandom_range(31) == 0);
      l = ($urandom_range(7) == 0);
      e = ($urandom_range(3) != 0);
      c = ($urandom_range(7) == 0);
      m = 2'($urandom_range(3));
      d = 4'($urandom_range(15));
      t = 4'($urandom_range(15));
      step(r, l, d, e, m, t, c);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
